// File: rtl/mestpro_pkg.sv
// -----------------------------------------------------------------------------
// mestpro_pkg
// Shared definitions for the mestpro program sequencer:
//   - opcode constants for the 8-bit accumulator datapath plus the local HALT
//   - sequencer state encoding
//   - small helper functions used by the sequencer decode logic
// -----------------------------------------------------------------------------
package mestpro_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_OUT  = 8'h07;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } seq_state_t;

    // True for opcodes the datapath understands and that get forwarded.
    function automatic logic is_dp_op(input logic [7:0] op);
        return (op >= OP_LOAD) && (op <= OP_OUT);
    endfunction

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'h01);
    endfunction

endpackage

// File: rtl/mestpro_prog_mem.sv
// -----------------------------------------------------------------------------
// mestpro_prog_mem
// DEPTH x 16 program store: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so a program survives a sequencer reset.
// Ports:
//   CLK    - clock, rising edge
//   we     - write enable (already qualified by the caller)
//   waddr  - write address
//   wdata  - write word {opcode, operand}
//   raddr  - read address
//   rdata  - combinational read data
// -----------------------------------------------------------------------------
module mestpro_prog_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem_r [DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mestpro_sequencer.sv
// -----------------------------------------------------------------------------
// mestpro_sequencer
// Program sequencer in front of the 8-bit accumulator datapath. The host loads
// a program while idle; START runs it from address 0, issuing one entry per
// cycle on INSTRUCTION/IN_DATA until HALT, end of memory, ABORT or an illegal
// opcode.
// Ports:
//   CLK          - clock, rising edge
//   RESET        - asynchronous, active-low reset
//   PROG_WE      - program write strobe (ignored while BUSY)
//   PROG_ADDR    - program write address
//   PROG_WDATA   - program word {opcode, operand}
//   START        - run request (honoured in IDLE/DONE/ERR)
//   ABORT        - stop and return to IDLE (beats START)
//   INSTRUCTION  - opcode to datapath, 0 = no operation
//   IN_DATA      - operand to datapath, holds when nothing is issued
//   BUSY/DONE/ERR- registered state flags
//   PC_OUT       - program counter
//   ISSUE_CNT    - instructions issued this run, saturating at 255
// -----------------------------------------------------------------------------
module mestpro_sequencer
    import mestpro_pkg::*;
#(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] HALT_OP = OP_HALT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [15:0]       PROG_WDATA,
    input  logic              START,
    input  logic              ABORT,
    output logic [7:0]        INSTRUCTION,
    output logic [7:0]        IN_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [7:0]        ISSUE_CNT
);

    localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_nxt_s;
    logic [7:0]        instr_r;
    logic [7:0]        instr_nxt_s;
    logic [7:0]        data_r;
    logic [7:0]        data_nxt_s;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              mem_we_s;
    logic [15:0]       mem_rdata_s;
    logic [7:0]        fetch_op_s;
    logic [7:0]        fetch_arg_s;

    // Writes are only accepted while idle so a running program cannot change.
    assign mem_we_s = PROG_WE & ~busy_r;

    mestpro_prog_mem #(
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .CLK   (CLK),
        .we    (mem_we_s),
        .waddr (PROG_ADDR),
        .wdata (PROG_WDATA),
        .raddr (pc_r),
        .rdata (mem_rdata_s)
    );

    assign fetch_op_s  = mem_rdata_s[15:8];
    assign fetch_arg_s = mem_rdata_s[7:0];

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        instr_nxt_s = OP_NOP;
        data_nxt_s  = data_r;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (ABORT) begin
                    state_nxt_s = ST_IDLE;
                end else if (START) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = PC_ZERO;
                    cnt_nxt_s   = 8'h00;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_RUN: begin
                if (ABORT) begin
                    // Entry fetched this cycle is dropped; PC and count stay visible.
                    state_nxt_s = ST_IDLE;
                end else if (is_dp_op(fetch_op_s)) begin
                    instr_nxt_s = fetch_op_s;
                    data_nxt_s  = fetch_arg_s;
                    cnt_nxt_s   = sat_inc8(cnt_r);
                    if (pc_r == PC_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
                    end
                end else if (fetch_op_s == HALT_OP) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers; flags track the next state so they
    // line up with the state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
            cnt_r   <= 8'h00;
            instr_r <= OP_NOP;
            data_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            instr_r <= instr_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
            err_r   <= (state_nxt_s == ST_ERR);
        end
    end

    assign INSTRUCTION = instr_r;
    assign IN_DATA     = data_r;
    assign BUSY        = busy_r;
    assign DONE        = done_r;
    assign ERR         = err_r;
    assign PC_OUT      = pc_r;
    assign ISSUE_CNT   = cnt_r;

endmodule

// File: doc/mestpro_sequencer.md
Name: mestpro_sequencer

Overview:
- Program sequencer for the 8-bit accumulator datapath (opcodes 1-7: LOAD A, ADD, SUB, AND, OR, XOR, OUT).
- Holds a small program memory, which the host loads while the sequencer is idle.
- On START, fetches entries in order and drives the datapath INSTRUCTION/IN_DATA inputs one entry per cycle until HALT, end of memory, ABORT or an illegal opcode.
- Sits between the host/testbench and the datapath instance.

Parameters:
ADDR_W, 4, program address width; DEPTH = 2**ADDR_W entries of 16 bits {opcode[15:8], operand[7:0]}.
HALT_OP, 8'hFF, sequencer-local stop opcode; never forwarded to the datapath.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
PROG_WE  input  1  program write strobe; honoured only when BUSY=0
PROG_ADDR  input  ADDR_W  program write address
PROG_WDATA  input  16  program word {opcode, operand}
START  input  1  single-cycle run request; honoured only in IDLE or DONE or ERR
ABORT  input  1  stop the run; returns to IDLE
INSTRUCTION  output  8  opcode to datapath; 0 = no operation
IN_DATA  output  8  operand to datapath
BUSY  output  1  high in RUN
DONE  output  1  high in DONE state
ERR  output  1  high in ERR state
PC_OUT  output  ADDR_W  current program counter
ISSUE_CNT  output  8  instructions issued in this run, saturating at 255

Behaviour:
- Reset (RESET=0, async) sets the state to IDLE and clears all outputs, PC and ISSUE_CNT to 0. Program memory is not reset; its contents are undefined until written.
- All outputs are registered. INSTRUCTION is 0 in every state except the cycle after an issue in RUN.
- States:
  - IDLE: if START=1, go to RUN, with PC=0 and ISSUE_CNT=0.
  - DONE and ERR: sticky. START goes to RUN (clears DONE/ERR, PC=0, ISSUE_CNT=0). ABORT goes to IDLE.
  - RUN, each cycle: read mem[PC] combinationally.
    - Opcode 1..7: INSTRUCTION<=opcode, IN_DATA<=operand, ISSUE_CNT++ (saturating). If PC==DEPTH-1, go to DONE (implicit halt); else PC++.
    - Opcode == HALT_OP: INSTRUCTION<=0, go to DONE. PC holds the HALT address.
    - Any other opcode, including 0: INSTRUCTION<=0, go to ERR. PC holds the faulting address.
- Latency: START is sampled at edge k. The first opcode appears on INSTRUCTION after edge k+1 and is consumed by the datapath at edge k+2. Issue rate is 1 per cycle, with no bubbles.
- ABORT has priority over everything in RUN. The next state is IDLE, INSTRUCTION<=0, and the entry read that cycle is not issued. PC and ISSUE_CNT hold their values for inspection.
- START and ABORT asserted together outside RUN: ABORT wins, go to IDLE. START in RUN is ignored.
- PROG_WE while BUSY=1 is ignored, so memory is unchanged.
- PROG_WE together with START in IDLE: the write completes at the same edge, so the first fetch (next cycle) sees the new word.
- The IN_DATA register holds its last value when nothing is issued.
- A mid-run reset returns to IDLE immediately, with INSTRUCTION=0. The datapath's own reset is separate.

Decomposition:
- Package mestpro_pkg holds:
  - opcode constants OP_NOP=0, OP_LOAD=1, OP_ADD=2, OP_SUB=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_OUT=7, OP_HALT=8'hFF
  - state encoding IDLE, RUN, DONE, ERR
- One natural sub-module: mestpro_prog_mem, the DEPTH x 16 register array with a synchronous write port and an asynchronous read port.

Test Plan:
- Program {01_05, 02_00, 01_03, 03_00, 07_00, FF_00}, START, sequencer wired to the datapath. INSTRUCTION sequence is 1,2,1,3,7 on consecutive cycles with IN_DATA 5 then 3 on the LOADs. DONE=1, ISSUE_CNT=5, PC_OUT=5, datapath OUT_DATA=8'h02.
- Entry 2 = 09_00 after two legal entries. ERR=1, PC_OUT=2, ISSUE_CNT=2, INSTRUCTION=0; START clears ERR and reruns from 0.
- All 16 entries = 02_00 with no HALT. 16 issues, then DONE with PC_OUT=15 and ISSUE_CNT=16.
- ABORT on the 3rd RUN cycle. Next cycle IDLE, BUSY=0, INSTRUCTION=0, ISSUE_CNT=2; a later START restarts at PC=0.
- PROG_WE to address 0 with 01_AA while BUSY. mem[0] is unchanged on the rerun. The same write issued together with START in IDLE makes IN_DATA=8'hAA on the first issue.
- RESET low mid-run (async, between edges). All outputs become 0 immediately; after release, START runs the preserved program.
